// File: rtl/pong_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_pkg : shared screen geometry, colours and renderer state encoding   |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package pong_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam logic [2:0] COL_BLACK = 3'b000;
   localparam logic [2:0] COL_WHITE = 3'b111;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_CLEAR   = 4'd1,
      ST_ERASE_L = 4'd2,
      ST_ERASE_R = 4'd3,
      ST_ERASE_B = 4'd4,
      ST_UPDATE  = 4'd5,
      ST_LATCH   = 4'd6,
      ST_DRAW_L  = 4'd7,
      ST_DRAW_R  = 4'd8,
      ST_DRAW_B  = 4'd9
`ifdef PONG_CENTER_NET_EN
      , ST_DRAW_NET = 4'd10
`endif
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pong_rect_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_rect_scanner : walks a width x height rectangle, column inner loop, |
// | one pixel per cycle while start is held; done flags the last pixel.      |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module pong_rect_scanner (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [8:0] org_x,
   input  logic [7:0] org_y,
   input  logic [7:0] width,
   input  logic [7:0] height,
   output logic [9:0] cx,
   output logic [9:0] cy,
   output logic       active,
   output logic       done
);

   logic [7:0] r_col;
   logic [7:0] r_row;
   logic       w_last_col;
   logic       w_last_row;

   assign w_last_col = (r_col == width - 8'd1);
   assign w_last_row = (r_row == height - 8'd1);
   assign active     = start;
   assign done       = start & w_last_col & w_last_row;

   // Widened so off-screen pixels compare correctly instead of wrapping
   assign cx = {1'b0, org_x} + {2'b00, r_col};
   assign cy = {2'b00, org_y} + {2'b00, r_row};

   always_ff @(posedge clk) begin
      if (!resetn || !start || done) begin
         r_col <= 8'd0;
         r_row <= 8'd0;
      end else if (w_last_col) begin
         r_col <= 8'd0;
         r_row <= r_row + 8'd1;
      end else begin
         r_col <= r_col + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pong_frame_renderer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pong_frame_renderer : frame tick, erase/update/draw raster sequencer and  |
// | screen clear for a 160x120 vga_adapter. PONG_CENTER_NET_EN adds a net.   |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
module pong_frame_renderer
   import pong_pkg::*;
#(
   parameter int PAD_W       = 2,
   parameter int PAD_H       = 16,
   parameter int BALL_SZ     = 2,
   parameter int LEFT_PAD_X  = 4,
   parameter int RIGHT_PAD_X = 154,
   parameter int FRAME_DIV   = 833333
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       run,
   input  logic       clear_req,
   input  logic [7:0] left_pad_y,
   input  logic [7:0] right_pad_y,
   input  logic [8:0] ball_x,
   input  logic [7:0] ball_y,
   output logic       update_pulse,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       overrun
);

   localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [DIV_W-1:0] r_div;
   logic             r_tick_pending;
   logic             r_clear_pending;
   logic [7:0]       r_old_left;
   logic [7:0]       r_old_right;
   logic [8:0]       r_old_ball_x;
   logic [7:0]       r_old_ball_y;

   logic             w_scan;
   logic             w_is_net;
   logic [8:0]       w_org_x;
   logic [7:0]       w_org_y;
   logic [7:0]       w_rect_w;
   logic [7:0]       w_rect_h;
   logic [2:0]       w_colour;
   logic [9:0]       w_cx;
   logic [9:0]       w_cy;
   logic             w_active;
   logic             w_done;
   logic             w_plot;
   logic             w_wrap;
   logic             w_take_tick;
   logic             w_clear_done;

   logic             r_update;
   logic [8:0]       r_x;
   logic [7:0]       r_y;
   logic [2:0]       r_colour;
   logic             r_plot;
   logic             r_busy;
   logic             r_overrun;

   pong_rect_scanner u_scanner (
      .clk    (clk),
      .resetn (resetn),
      .start  (w_scan),
      .org_x  (w_org_x),
      .org_y  (w_org_y),
      .width  (w_rect_w),
      .height (w_rect_h),
      .cx     (w_cx),
      .cy     (w_cy),
      .active (w_active),
      .done   (w_done)
   );

   assign w_wrap       = (r_div == DIV_LAST);
   assign w_take_tick  = (r_state == ST_IDLE) & ~r_clear_pending & r_tick_pending;
   assign w_clear_done = (r_state == ST_CLEAR) & w_done;

   // Net dashes: 4 rows on, 4 rows off
   assign w_plot = w_active & ~(w_is_net & w_cy[2]) &
                   (w_cx < 10'(SCREEN_W)) & (w_cy < 10'(SCREEN_H));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (r_clear_pending)     w_state_next = ST_CLEAR;
            else if (r_tick_pending) w_state_next = ST_ERASE_L;
         end
         ST_CLEAR:   if (w_done) w_state_next = ST_IDLE;
         ST_ERASE_L: if (w_done) w_state_next = ST_ERASE_R;
         ST_ERASE_R: if (w_done) w_state_next = ST_ERASE_B;
         ST_ERASE_B: if (w_done) w_state_next = ST_UPDATE;
         ST_UPDATE:  w_state_next = ST_LATCH;
         ST_LATCH:   w_state_next = ST_DRAW_L;
         ST_DRAW_L:  if (w_done) w_state_next = ST_DRAW_R;
         ST_DRAW_R:  if (w_done) w_state_next = ST_DRAW_B;
`ifdef PONG_CENTER_NET_EN
         ST_DRAW_B:   if (w_done) w_state_next = ST_DRAW_NET;
         ST_DRAW_NET: if (w_done) w_state_next = ST_IDLE;
`else
         ST_DRAW_B:  if (w_done) w_state_next = ST_IDLE;
`endif
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // Erase and draw share geometry; draw runs after LATCH, so both use old regs
   always_comb begin
      w_scan   = 1'b0;
      w_is_net = 1'b0;
      w_org_x  = 9'd0;
      w_org_y  = 8'd0;
      w_rect_w = 8'd1;
      w_rect_h = 8'd1;
      w_colour = COL_BLACK;
      case (r_state)
         ST_CLEAR: begin
            w_scan   = 1'b1;
            w_rect_w = 8'(SCREEN_W);
            w_rect_h = 8'(SCREEN_H);
         end
         ST_ERASE_L, ST_DRAW_L: begin
            w_scan   = 1'b1;
            w_org_x  = 9'(LEFT_PAD_X);
            w_org_y  = r_old_left;
            w_rect_w = 8'(PAD_W);
            w_rect_h = 8'(PAD_H);
            w_colour = (r_state == ST_DRAW_L) ? COL_WHITE : COL_BLACK;
         end
         ST_ERASE_R, ST_DRAW_R: begin
            w_scan   = 1'b1;
            w_org_x  = 9'(RIGHT_PAD_X);
            w_org_y  = r_old_right;
            w_rect_w = 8'(PAD_W);
            w_rect_h = 8'(PAD_H);
            w_colour = (r_state == ST_DRAW_R) ? COL_WHITE : COL_BLACK;
         end
         ST_ERASE_B, ST_DRAW_B: begin
            w_scan   = 1'b1;
            w_org_x  = r_old_ball_x;
            w_org_y  = r_old_ball_y;
            w_rect_w = 8'(BALL_SZ);
            w_rect_h = 8'(BALL_SZ);
            w_colour = (r_state == ST_DRAW_B) ? COL_WHITE : COL_BLACK;
         end
`ifdef PONG_CENTER_NET_EN
         ST_DRAW_NET: begin
            w_scan   = 1'b1;
            w_is_net = 1'b1;
            w_org_x  = 9'(SCREEN_W / 2);
            w_rect_h = 8'(SCREEN_H);
            w_colour = COL_WHITE;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_div           <= '0;
         r_tick_pending  <= 1'b0;
         r_clear_pending <= 1'b0;
         r_overrun       <= 1'b0;
         r_old_left      <= 8'd0;
         r_old_right     <= 8'd0;
         r_old_ball_x    <= 9'd0;
         r_old_ball_y    <= 8'd0;
      end else begin
         r_div           <= w_wrap ? '0 : r_div + DIV_W'(1);
         r_tick_pending  <= (r_tick_pending & ~w_take_tick) | (w_wrap & run & ~r_tick_pending);
         r_overrun       <= w_wrap & run & r_tick_pending;
         r_clear_pending <= clear_req | (r_clear_pending & ~w_clear_done);
         if (r_state == ST_LATCH) begin
            r_old_left   <= left_pad_y;
            r_old_right  <= right_pad_y;
            r_old_ball_x <= ball_x;
            r_old_ball_y <= ball_y;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_x      <= 9'd0;
         r_y      <= 8'd0;
         r_colour <= COL_BLACK;
         r_plot   <= 1'b0;
         r_update <= 1'b0;
         r_busy   <= 1'b1;
      end else begin
         r_x      <= w_cx[8:0];
         r_y      <= w_cy[7:0];
         r_colour <= w_colour;
         r_plot   <= w_plot;
         r_update <= (r_state == ST_UPDATE);
         r_busy   <= (w_state_next != ST_IDLE);
      end
   end

   assign x            = r_x;
   assign y            = r_y;
   assign colour       = r_colour;
   assign plot         = r_plot;
   assign update_pulse = r_update;
   assign busy         = r_busy;
   assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Raster sequencer between the Pong game datapath and the 160x120 vga_adapter.
- Generates the frame tick and gives game logic a one-cycle update pulse.
- Erases the previous paddles and ball, draws them at new positions, and clears the screen after reset or on request.
- Drives vga_adapter x, y, colour and plot, one pixel per cycle.

Parameters:
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels
- PAD_W, 2, paddle width
- PAD_H, 16, paddle height
- BALL_SZ, 2, ball side length (square)
- LEFT_PAD_X, 4, left paddle column
- RIGHT_PAD_X, 154, right paddle column
- FRAME_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz)

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous active-low reset
- run  in  1  1 = frame ticks start frames; 0 = ticks ignored
- clear_req  in  1  request full-screen clear; single-cycle pulse, held pending
- left_pad_y  in  8  left paddle top row
- right_pad_y  in  8  right paddle top row
- ball_x  in  9  ball left column
- ball_y  in  8  ball top row
- update_pulse  out  1  one-cycle strobe: game logic moves pads/ball now
- x  out  9  pixel column to vga_adapter
- y  out  8  pixel row to vga_adapter
- colour  out  3  RGB to vga_adapter
- plot  out  1  write enable to vga_adapter
- busy  out  1  1 whenever state != IDLE
- overrun  out  1  one-cycle pulse when a tick arrives while a tick is already pending

Behaviour:
- Outputs and reset:
  - All outputs are registered.
  - Reset values: x=0, y=0, colour=0, plot=0, update_pulse=0, overrun=0, busy=1.
  - Reset also sets state=CLEAR, scan counters=0, old-position registers=0, tick_pending=0, clear_pending=0.
  - A reset asserted mid-operation aborts the current scan immediately.
- Frame divider:
  - Counts 0..FRAME_DIV-1.
  - At wrap it sets tick_pending if run=1.
  - If tick_pending is already set at wrap, overrun pulses and the new tick is dropped.
- Scan order: column offset is the inner loop, row offset the outer loop, both starting at 0. One pixel per cycle, with no idle cycle between rectangles.
- Output timing: the registered outputs carry pixel (state, cx, cy) one cycle later.
- Clipping: a pixel with x>=SCREEN_W or y>=SCREEN_H still consumes a cycle but is emitted with plot=0. Arithmetic is width-extended to 10 bits before the compare.
- States:
  - CLEAR:
    - Scans SCREEN_W x SCREEN_H with colour 000 (19200 cycles).
    - Then goes to IDLE and clears clear_pending.
  - IDLE:
    - If clear_pending, go to CLEAR. clear_pending has priority over tick_pending.
    - Else if tick_pending, go to ERASE_L and clear tick_pending.
  - ERASE_L, ERASE_R, ERASE_B:
    - Scan the old rectangles (registered positions) with colour 000.
    - Pads are PAD_W x PAD_H; the ball is BALL_SZ x BALL_SZ.
  - UPDATE: 1 cycle; update_pulse=1.
  - LATCH: 1 cycle; capture the four position inputs into the old-position registers.
  - DRAW_L, DRAW_R, DRAW_B: same geometry as erase, colour 111. DRAW_B then goes to IDLE.
- Latency:
  - Tick-to-IDLE with default sizes is 32+32+4+1+1+32+32+4 = 138 cycles.
  - CLEAR is 19200 cycles.
- clear_req arriving mid-frame sets clear_pending; the current frame finishes first.
- plot=0 in IDLE, UPDATE and LATCH.

Optional Feature:
- Macro: PONG_CENTER_NET_EN.
- Defined:
  - DRAW_B goes to DRAW_NET, which scans column SCREEN_W/2, rows 0..SCREEN_H-1 (120 cycles), then goes to IDLE.
  - plot=1 only when row bit[2]==0 (dashed 4 on / 4 off), colour 111.
  - The net is redrawn every frame so ball erase cannot leave gaps.
  - Tick-to-IDLE latency becomes 258 cycles.
- Undefined: no DRAW_NET state; DRAW_B goes directly to IDLE.

Decomposition:
- Package pong_pkg holds:
  - SCREEN_W/SCREEN_H constants
  - colour constants COL_BLACK=000, COL_WHITE=111
  - the state enum.
- Sub-module pong_rect_scanner:
  - Inputs: start, origin x/y, width, height.
  - Outputs: cx, cy, active, done.
  - done is asserted on the last pixel cycle.
  - One instance is reused by every scan state.

Test Plan:
1. Reset released:
   - Exactly 19200 plot=1 cycles, all colour 000, covering x 0..159, y 0..119.
   - busy then falls.
2. FRAME_DIV=300, run=1, left=10, right=20, ball=(80,60), first frame:
   - Erase at old position (0,0), 68 plot cycles.
   - update_pulse once.
   - Draw: 32 white pixels at x 4..5, y 10..25; 32 at x 154..155, y 20..35; 4 at x 80..81, y 60..61.
   - busy is high for 138 cycles.
3. Second frame after ball moves to (81,61): the erase phase writes black at (80..81, 60..61) before the white write at (81..82, 61..62).
4. ball_x=159, ball_y=119: only pixel (159,119) is plotted for the ball; the other 3 ball cycles have plot=0, with no wrap to x=0.
5. clear_req pulsed during DRAW_R: the frame completes, then CLEAR runs; a tick arriving meanwhile is serviced after CLEAR; a second tick arriving during CLEAR pulses overrun.
6. resetn low for 1 cycle during DRAW_L: plot=0 the next cycle, then a full CLEAR restarts at (0,0). run=0 means no update_pulse for 3 divider periods.
